// File: rtl/uf_union_engine.sv
// Union stage of the union-find decoder: resolves both roots through the find engine and links them.
// Define UF_UNION_SIZE_EN for union-by-size; otherwise the smaller root wins and only the parent entry is written.
module uf_union_engine #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] SIZE_BASE = WIDTH'(32'h0000_1000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] node_a,
    input  logic [WIDTH-1:0] node_b,
    output logic             done,
    output logic             busy,
    output logic             merged,
    output logic [WIDTH-1:0] new_root,
    output logic             find_start,
    output logic [WIDTH-1:0] find_node,
    input  logic [WIDTH-1:0] find_root,
    input  logic             find_done,
    output logic             mem_rd_en,
    output logic             mem_wr_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready
);
    // state   | meaning
    // IDLE    | waiting for start
    // FA_*    | find request / wait for root of node a
    // FB_*    | find request / wait for root of node b
    // CMP     | same root -> DONE, else begin linking
    // SA_*    | read size of root a
    // SB_*    | read size of root b
    // LINK    | pick winner/loser, issue parent write
    // WP_*    | parent[loser] = winner
    // WS_*    | size[winner] = saturated sum
    // DONE    | done pulse, back to IDLE
    typedef enum logic [3:0] {
        IDLE, FA_REQ, FA_WAIT, FB_REQ, FB_WAIT, CMP,
        SA_REQ, SA_WAIT, SB_REQ, SB_WAIT, LINK,
        WP_REQ, WP_WAIT, WS_REQ, WS_WAIT, DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] node_b_q;
    logic [WIDTH-1:0] root_a;
    logic [WIDTH-1:0] root_b;
    logic             a_wins;
    logic [WIDTH-1:0] winner;
    logic [WIDTH-1:0] loser;

`ifdef UF_UNION_SIZE_EN
    logic [WIDTH-1:0] size_a;
    logic [WIDTH-1:0] size_b;
    logic [WIDTH:0]   size_sum;
    logic [WIDTH-1:0] size_sat;

    assign a_wins   = (size_a >= size_b);
    assign size_sum = {1'b0, size_a} + {1'b0, size_b};
    assign size_sat = size_sum[WIDTH] ? '1 : size_sum[WIDTH-1:0];
`else
    logic unused_cfg;

    // Roots differ whenever LINK is reached, so <= only ever resolves a strict ordering.
    assign a_wins     = (root_a <= root_b);
    assign unused_cfg = ^{mem_rdata, SIZE_BASE};
`endif

    assign winner = a_wins ? root_a : root_b;
    assign loser  = a_wins ? root_b : root_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            node_b_q   <= '0;
            root_a     <= '0;
            root_b     <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            merged     <= 1'b0;
            new_root   <= '0;
            find_start <= 1'b0;
            find_node  <= '0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef UF_UNION_SIZE_EN
            size_a     <= '0;
            size_b     <= '0;
`endif
        end else begin
            find_start <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    node_b_q   <= node_b;
                    find_node  <= node_a;
                    find_start <= 1'b1;
                    busy       <= 1'b1;
                    state      <= FA_REQ;
                end
                FA_REQ: state <= FA_WAIT;
                FA_WAIT: if (find_done) begin
                    root_a     <= find_root;
                    find_node  <= node_b_q;
                    find_start <= 1'b1;
                    state      <= FB_REQ;
                end
                FB_REQ: state <= FB_WAIT;
                FB_WAIT: if (find_done) begin
                    root_b <= find_root;
                    state  <= CMP;
                end
                CMP: begin
                    if (root_a == root_b) begin
                        merged   <= 1'b0;
                        new_root <= root_a;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
`ifdef UF_UNION_SIZE_EN
                        mem_rd_en <= 1'b1;
                        mem_addr  <= SIZE_BASE + root_a;
                        state     <= SA_REQ;
`else
                        state     <= LINK;
`endif
                    end
                end
`ifdef UF_UNION_SIZE_EN
                SA_REQ: state <= SA_WAIT;
                SA_WAIT: if (mem_ready) begin
                    size_a    <= mem_rdata;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= SIZE_BASE + root_b;
                    state     <= SB_REQ;
                end
                SB_REQ: state <= SB_WAIT;
                SB_WAIT: if (mem_ready) begin
                    size_b <= mem_rdata;
                    state  <= LINK;
                end
`endif
                LINK: begin
                    mem_wr_en <= 1'b1;
                    mem_addr  <= loser;
                    mem_wdata <= winner;
                    new_root  <= winner;
                    merged    <= 1'b1;
                    state     <= WP_REQ;
                end
                WP_REQ: state <= WP_WAIT;
                WP_WAIT: if (mem_ready) begin
`ifdef UF_UNION_SIZE_EN
                    mem_wr_en <= 1'b1;
                    mem_addr  <= SIZE_BASE + new_root;
                    mem_wdata <= size_sat;
                    state     <= WS_REQ;
`else
                    done      <= 1'b1;
                    state     <= DONE;
`endif
                end
`ifdef UF_UNION_SIZE_EN
                WS_REQ: state <= WS_WAIT;
                WS_WAIT: if (mem_ready) begin
                    done  <= 1'b1;
                    state <= DONE;
                end
`endif
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uf_union_engine.sv
// Self-checking bench for uf_union_engine: behavioural find engine and parent/size memory plus a union reference model.
// Expectations follow UF_UNION_SIZE_EN the same way the design does.
module tb_uf_union_engine;
    localparam logic [31:0] SB = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] node_a;
    logic [31:0] node_b;
    logic        done;
    logic        busy;
    logic        merged;
    logic [31:0] new_root;
    logic        find_start;
    logic [31:0] find_node;
    logic [31:0] find_root;
    logic        find_done;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    uf_union_engine dut (
        .clk(clk), .rst(rst), .start(start), .node_a(node_a), .node_b(node_b),
        .done(done), .busy(busy), .merged(merged), .new_root(new_root),
        .find_start(find_start), .find_node(find_node), .find_root(find_root), .find_done(find_done),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] parent [16];
    logic [31:0] sz     [16];
    logic [63:0] wr_log [$];
    int tests = 0, fails = 0;
    int find_lat = 1, mem_lat = 1;
    int done_cnt = 0, wr_cnt = 0, rd_cnt = 0, fs_cnt = 0;
    int mem_err = 0, find_err = 0;

    function automatic logic [31:0] ref_root(input logic [31:0] n);
        logic [31:0] r;
        r = n & 32'hF;
        for (int k = 0; k < 32; k++)
            if (parent[r[3:0]] != r) r = parent[r[3:0]];
        return r;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        logic [31:0] off;
        if (addr >= SB) begin
            off = addr - SB;
            return sz[off[3:0]];
        end
        return parent[addr[3:0]];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic init_forest(input bit rand_sizes);
        for (int i = 0; i < 16; i++) begin
            parent[i] = 32'(i);
            sz[i] = rand_sizes ? 32'($urandom_range(1, 8)) : 32'd1;
        end
    endtask

    // find engine: answers find_lat cycles after the request with the root of the current forest
    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] req;
        pend = 0; cnt = 0; req = 0;
        find_done = 0; find_root = 0;
        forever begin
            @(negedge clk);
            find_done = 0;
            if (pend) begin
                if (find_start) find_err++;
                if (cnt <= 1) begin
                    find_done = 1;
                    find_root = ref_root(req);
                    pend = 0;
                end else cnt--;
            end else if (find_start) begin
                pend = 1; cnt = find_lat; req = find_node;
            end
        end
    end

    // memory: answers mem_lat cycles after the request, checks the request stays stable while waiting
    initial begin
        logic        pend, is_wr;
        int          cnt;
        logic [31:0] ra, rw;
        pend = 0; is_wr = 0; cnt = 0; ra = 0; rw = 0;
        mem_ready = 0; mem_rdata = 0;
        forever begin
            @(negedge clk);
            mem_ready = 0;
            if (pend) begin
                if (busy && (mem_addr !== ra || mem_wdata !== rw || mem_rd_en || mem_wr_en)) mem_err++;
                if (cnt <= 1) begin
                    mem_ready = 1;
                    mem_rdata = is_wr ? 32'h0 : mem_read(ra);
                    if (is_wr) wr_log.push_back({ra, rw});
                    pend = 0;
                end else cnt--;
            end else if (mem_rd_en || mem_wr_en) begin
                if (mem_rd_en && mem_wr_en) mem_err++;
                pend = 1; cnt = mem_lat; ra = mem_addr; rw = mem_wdata; is_wr = mem_wr_en;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (mem_wr_en) wr_cnt++;
            if (mem_rd_en) rd_cnt++;
            if (find_start) fs_cnt++;
        end
    end

    // Caller must be sitting just after a negedge.
    task automatic do_union(input logic [31:0] a, input logic [31:0] b, input int lf, input int lm,
                            input bit stray, input string nm);
        logic [31:0] ra, rb, w, l;
        logic [32:0] sum;
        logic        exp_m;
        logic [63:0] exp_w [$];
        int exp_lat, exp_rd, s_done, s_wr, s_rd, s_fs, s_me, s_fe, base, cyc;
        bit seen;
        ra = ref_root(a);
        rb = ref_root(b);
        exp_m = (ra != rb);
        w = ra; l = rb; sum = '0; exp_rd = 0;
        exp_lat = 2 * (1 + lf) + 2;
        if (exp_m) begin
`ifdef UF_UNION_SIZE_EN
            if (sz[ra[3:0]] >= sz[rb[3:0]]) begin w = ra; l = rb; end
            else begin w = rb; l = ra; end
            sum = {1'b0, sz[ra[3:0]]} + {1'b0, sz[rb[3:0]]};
            if (sum[32]) sum = 33'h0_FFFF_FFFF;
            exp_w.push_back({l, w});
            exp_w.push_back({SB + w, sum[31:0]});
            exp_rd = 2;
            exp_lat += 4 * (1 + lm) + 1;
`else
            w = (ra < rb) ? ra : rb;
            l = (ra < rb) ? rb : ra;
            exp_w.push_back({l, w});
            exp_lat += 1 + (1 + lm);
`endif
        end
        find_lat = lf; mem_lat = lm;
        s_done = done_cnt; s_wr = wr_cnt; s_rd = rd_cnt; s_fs = fs_cnt;
        s_me = mem_err; s_fe = find_err; base = wr_log.size();
        node_a = a; node_b = b; start = 1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = stray && (cyc == 3);
            if (start) begin
                node_a = 32'($urandom_range(0, 15));
                node_b = 32'($urandom_range(0, 15));
            end
            if (cyc == 1) check({nm, " busy after start"}, busy, 1);
            if (done) seen = 1;
        end
        check({nm, " done seen"}, seen, 1);
        check({nm, " latency"}, cyc, exp_lat);
        repeat (3) @(negedge clk);
        check({nm, " merged"}, merged, exp_m);
        check({nm, " new_root"}, new_root, w);
        check({nm, " done pulses"}, done_cnt - s_done, 1);
        check({nm, " busy cleared"}, busy, 0);
        check({nm, " write pulses"}, wr_cnt - s_wr, exp_w.size());
        check({nm, " read pulses"}, rd_cnt - s_rd, exp_rd);
        check({nm, " find pulses"}, fs_cnt - s_fs, 2);
        check({nm, " mem protocol"}, mem_err - s_me, 0);
        check({nm, " find protocol"}, find_err - s_fe, 0);
        check({nm, " write log size"}, wr_log.size() - base, exp_w.size());
        for (int i = 0; i < exp_w.size(); i++)
            if (base + i < wr_log.size())
                check($sformatf("%s write %0d", nm, i), wr_log[base + i], exp_w[i]);
        if (exp_m) begin
            parent[l[3:0]] = w;
`ifdef UF_UNION_SIZE_EN
            sz[w[3:0]] = sum[31:0];
`endif
        end
    endtask

    initial begin
        int s_wr, s_rd, s_done, n;
        rst = 1; start = 0; node_a = 0; node_b = 0;
        init_forest(0);
        repeat (3) @(negedge clk);
        rst = 0;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset merged", merged, 0);
        check("reset new_root", new_root, 0);
        check("reset find_start", find_start, 0);
        check("reset mem_en", {mem_rd_en, mem_wr_en}, 0);
        check("reset mem_addr", mem_addr, 0);
        @(negedge clk);

        init_forest(0);
        do_union(3, 7, 1, 1, 0, "fresh");

        init_forest(0);
        sz[5] = 4; sz[9] = 10;
        do_union(5, 9, 1, 1, 0, "size_order");

        init_forest(0);
        parent[4] = 2;
        do_union(4, 2, 1, 1, 0, "joined");

        init_forest(0);
        sz[1] = 32'hFFFF_FFF0; sz[6] = 32'h20;
        do_union(1, 6, 1, 1, 0, "saturate");

        init_forest(0);
        do_union(2, 11, 3, 5, 1, "backpressure");

        init_forest(0);
        do_union(8, 8, 2, 1, 1, "self");

        // reset while the parent write is outstanding
        init_forest(0);
        find_lat = 1; mem_lat = 6;
        s_wr = wr_cnt;
        node_a = 3; node_b = 7; start = 1;
        @(negedge clk);
        start = 0;
        n = 0;
        while (wr_cnt == s_wr && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst write issued", wr_cnt != s_wr, 1);
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst mem_wr_en", mem_wr_en, 0);
        s_wr = wr_cnt; s_rd = rd_cnt; s_done = done_cnt;
        repeat (15) @(negedge clk);
        check("rst no writes", wr_cnt - s_wr, 0);
        check("rst no reads", rd_cnt - s_rd, 0);
        check("rst no done", done_cnt - s_done, 0);
        check("rst idle", busy, 0);
        check("rst merged", merged, 0);
        init_forest(0);
        do_union(3, 7, 1, 1, 0, "after_rst");

        init_forest(1);
        for (int t = 0; t < 24; t++) begin
            do_union(32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)),
                     int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                     1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
